// File: rtl/fifo_rd_stream_if.sv
// Read-side stream bundle of the async FIFO.
// The master drives valid/data; the slave drives ready.
interface fifo_rd_stream_if #(
  parameter int DATASIZE = 8
);
  logic                m_valid;
  logic                m_ready;
  logic [DATASIZE-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Async FIFO read controller: read pointer, empty flag and
// a 2-entry buffer that hides the one-cycle memory latency.
module fifo_rd_stream #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                rclken,
  output logic [ADDRSIZE-1:0] raddr,
  input  logic [DATASIZE-1:0] mem_rdata,
  fifo_rd_stream_if.master    m
);

  logic [ADDRSIZE:0]   rbin;
  logic [ADDRSIZE:0]   rbinnext;
  logic [ADDRSIZE:0]   rgraynext;
  logic [1:0]          occ;
  logic [1:0]          occ_n;
  logic [2:0]          occ_sum;
  logic                infl;
  logic                pop;
  logic [DATASIZE-1:0] head;
  logic [DATASIZE-1:0] head_n;
  logic [DATASIZE-1:0] tail;
  logic [DATASIZE-1:0] tail_n;

  assign m.m_valid = (occ != 2'd0);
  assign m.m_data  = head;
  assign pop       = m.m_valid && m.m_ready;

  // occ + infl - pop never underflows: pop needs occ >= 1
  assign occ_sum = {1'b0, occ}
                 + {2'b00, infl}
                 - {2'b00, pop};
  assign occ_n   = occ_sum[1:0];

  assign rclken    = !rempty && (occ_sum < 3'd2);
  assign raddr     = rbin[ADDRSIZE-1:0];
  assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rclken};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
    end else begin
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      rempty <= (rgraynext == rq2_wptr);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      infl <= 1'b0;
      occ  <= 2'd0;
    end else begin
      infl <= rclken;
      occ  <= occ_n;
    end
  end

  // Capture lands in the slot that is the tail after any pop
  always_comb begin
    head_n = head;
    tail_n = tail;
    unique case (1'b1)
      (occ == 2'd0): begin
        if (infl) head_n = mem_rdata;
      end
      (occ == 2'd1): begin
        if (infl && pop) head_n = mem_rdata;
        if (infl && !pop) tail_n = mem_rdata;
      end
      default: begin
        if (pop) head_n = tail;
        if (pop && infl) tail_n = mem_rdata;
      end
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head_n;
      tail <= tail_n;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a memory model
// and a scoreboard queue checked on every stream pop.
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic [4:0] rq2_wptr;
  logic [4:0] rptr;
  logic       rempty;
  logic       rclken;
  logic [3:0] raddr;
  logic [7:0] mem_rdata;

  fifo_rd_stream_if #(.DATASIZE(8)) s ();

  fifo_rd_stream #(.DATASIZE(8), .ADDRSIZE(4)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rq2_wptr  (rq2_wptr),
    .rptr      (rptr),
    .rempty    (rempty),
    .rclken    (rclken),
    .raddr     (raddr),
    .mem_rdata (mem_rdata),
    .m         (s.master)
  );

  always #5 rclk = ~rclk;

  logic [7:0] mem [16];
  logic [7:0] q [$];
  logic [4:0] wbin;
  int         total = 0;
  int         bad = 0;
  int         popped = 0;

  always @(posedge rclk)
    if (rclken) mem_rdata <= mem[raddr];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(logic [7:0] v);
    mem[wbin[3:0]] = v;
    q.push_back(v);
    wbin = wbin + 5'd1;
    rq2_wptr = wbin ^ (wbin >> 1);
  endtask

  always @(negedge rclk) begin
    if (rrst_n === 1'b1 && s.m_valid === 1'b1 &&
        s.m_ready === 1'b1) begin
      total++;
      assert (q.size() > 0) else begin
        bad++;
        $error("FAIL extra_word got=%0h exp=none",
               s.m_data);
      end
      if (q.size() > 0) begin
        chk("order", {24'd0, s.m_data},
            {24'd0, q.pop_front()});
        popped++;
      end
    end
  end

  initial begin
    int cv, ce, rv, re, cyc;
    logic pv, pe;
    rrst_n = 1'b0;
    s.m_ready = 1'b0;
    rq2_wptr = '0;
    wbin = '0;
    #12;
    chk("rst_rempty", rempty, 1);
    chk("rst_valid", s.m_valid, 0);
    chk("rst_rclken", rclken, 0);
    chk("rst_rptr", rptr, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_data", s.m_data, 0);
    tick();
    rrst_n = 1'b1;

    ce = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      if (rclken) ce++;
    end
    chk("idle_rclken", ce, 0);
    chk("idle_rptr", rptr, 0);
    chk("idle_valid", s.m_valid, 0);

    tick();
    s.m_ready = 1'b1;
    push(8'hA5);
    @(negedge rclk);
    chk("lat_en0", rclken, 0);
    @(negedge rclk);
    chk("lat_en1", rclken, 1);
    @(negedge rclk);
    chk("lat_v2", s.m_valid, 0);
    @(negedge rclk);
    chk("lat_v3", s.m_valid, 1);
    chk("lat_data", s.m_data, 8'hA5);
    @(negedge rclk);
    chk("lat_v4", s.m_valid, 0);
    chk("lat_rptr", rptr, 1);
    chk("lat_rempty", rempty, 1);

    tick();
    for (int i = 0; i < 16; i++) push(8'(i));
    cv = 0; ce = 0; rv = 0; re = 0;
    pv = 0; pe = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge rclk);
      if (s.m_valid) cv++;
      if (rclken) ce++;
      if (s.m_valid && !pv) rv++;
      if (rclken && !pe) re++;
      pv = s.m_valid;
      pe = rclken;
    end
    chk("tp_valid_cnt", cv, 16);
    chk("tp_valid_runs", rv, 1);
    chk("tp_en_cnt", ce, 16);
    chk("tp_en_runs", re, 1);
    chk("tp_q_empty", q.size(), 0);

    tick();
    s.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i));
    ce = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      if (rclken) ce++;
      if (s.m_valid) chk("stall_data", s.m_data, 0);
    end
    chk("stall_reads", ce, 2);
    chk("stall_valid", s.m_valid, 1);
    tick();
    s.m_ready = 1'b1;
    cyc = 0;
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      @(negedge rclk);
      #1;
      cyc++;
    end
    chk("drain_cycles", cyc, 16);
    chk("drain_q_empty", q.size(), 0);

    tick();
    rrst_n = 1'b0;
    s.m_ready = 1'b0;
    wbin = '0;
    rq2_wptr = '0;
    popped = 0;
    q.delete();
    tick();
    rrst_n = 1'b1;
    begin
      int written;
      written = 0;
      for (int i = 0; i < 3000 && popped < 40; i++) begin
        tick();
        s.m_ready = 1'($urandom_range(0, 1));
        if (written < 40 && (written - popped) < 16) begin
          push(8'($urandom_range(0, 255)));
          written++;
        end
      end
    end
    chk("wrap_popped", popped, 40);
    tick();
    tick();
    chk("wrap_rptr", rptr, 5'b01100);
    chk("wrap_q_empty", q.size(), 0);

    s.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
    for (int i = 0; i < 8; i++) tick();
    chk("mid_valid", s.m_valid, 1);
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_valid", s.m_valid, 0);
    chk("mid_rst_rptr", rptr, 0);
    chk("mid_rst_rempty", rempty, 1);
    chk("mid_rst_rclken", rclken, 0);
    q.delete();
    wbin = '0;
    rq2_wptr = '0;
    popped = 0;
    tick();
    tick();
    rrst_n = 1'b1;
    s.m_ready = 1'b1;
    cv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      if (s.m_valid) cv++;
    end
    chk("post_rst_stale", cv, 0);
    chk("post_rst_rptr", rptr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
